mips_exec_ctrl: RTL and testbench

//  Single-cycle MIPS32 control slice: main opcode decoder, ALU-control decoder and 32-bit ALU with zero flag.

---
 rtl/mips_ctrl_pkg.sv | 43 ++++
 rtl/alu_core.sv | 28 ++
 rtl/mips_exec_ctrl.sv | 122 ++++++++++++
 tb/tb_mips_exec_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS32 execute-stage control slice.
package mips_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 32;

  // Main opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation class produced by the main decoder
  localparam logic [2:0] AOP_ADD   = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_FUNCT = 3'b010;
  localparam logic [2:0] AOP_AND   = 3'b011;
  localparam logic [2:0] AOP_OR    = 3'b100;
  localparam logic [2:0] AOP_SLT   = 3'b101;

  // ALU function select
  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_XOR = 3'b011;
  localparam logic [2:0] SEL_NOR = 3'b100;
  localparam logic [2:0] SEL_SUB = 3'b110;
  localparam logic [2:0] SEL_SLT = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU; operand order is b op a (b = rs, a = rt/imm).
module alu_core
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] result
);

  // Function select; unused code 101 yields zero, add/sub wrap silently
  always_comb begin
    result = '0;
    unique case (sel)
      SEL_AND: result = b & a;
      SEL_OR:  result = b | a;
      SEL_ADD: result = b + a;
      SEL_XOR: result = b ^ a;
      SEL_NOR: result = ~(b | a);
      SEL_SUB: result = b - a;
      SEL_SLT: result = ($signed(b) < $signed(a)) ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mips_exec_ctrl.sv
// MIPS32 control slice: main decoder, ALU-control decoder, ALU and EX register.
// Decode outputs are combinational; ALU result, zero and illegal flags are registered.
module mips_exec_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [5:0]       opCode,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             regDst,
  output logic             branch,
  output logic             memRead,
  output logic             memtoReg,
  output logic             memWrite,
  output logic             aluSrc,
  output logic             regWrite,
  output logic             jump,
  output logic [2:0]       aluOp,
  output logic [2:0]       aluSel,
  output logic [WIDTH-1:0] out,
  output logic             zeroFlag,
  output logic             illegal
);

  // {regDst,aluSrc,memtoReg,regWrite,memRead,memWrite,branch,jump}
  logic [7:0]       ctrl;
  logic             op_bad;
  logic             fn_bad;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  // Main opcode decoder
  always_comb begin
    ctrl   = 8'b0000_0000;
    aluOp  = AOP_ADD;
    op_bad = 1'b0;
    unique case (opCode)
      OP_RTYPE: begin ctrl = 8'b1001_0000; aluOp = AOP_FUNCT; end
      OP_LW:    begin ctrl = 8'b0111_1000; aluOp = AOP_ADD;   end
      OP_SW:    begin ctrl = 8'b0100_0100; aluOp = AOP_ADD;   end
      OP_BEQ:   begin ctrl = 8'b0000_0010; aluOp = AOP_SUB;   end
      OP_ADDI:  begin ctrl = 8'b0101_0000; aluOp = AOP_ADD;   end
      OP_ANDI:  begin ctrl = 8'b0101_0000; aluOp = AOP_AND;   end
      OP_ORI:   begin ctrl = 8'b0101_0000; aluOp = AOP_OR;    end
      OP_SLTI:  begin ctrl = 8'b0101_0000; aluOp = AOP_SLT;   end
      OP_J:     begin ctrl = 8'b0000_0001; aluOp = AOP_ADD;   end
      default:  op_bad = 1'b1;
    endcase
  end

  assign {regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, jump} = ctrl;

  // ALU-control decoder; unknown R-type funct falls back to ADD and flags illegal
  always_comb begin
    aluSel = SEL_ADD;
    fn_bad = 1'b0;
    unique case (aluOp)
      AOP_ADD: aluSel = SEL_ADD;
      AOP_SUB: aluSel = SEL_SUB;
      AOP_AND: aluSel = SEL_AND;
      AOP_OR:  aluSel = SEL_OR;
      AOP_SLT: aluSel = SEL_SLT;
      AOP_FUNCT: begin
        unique case (funct)
          FN_ADD:  aluSel = SEL_ADD;
          FN_SUB:  aluSel = SEL_SUB;
          FN_AND:  aluSel = SEL_AND;
          FN_OR:   aluSel = SEL_OR;
          FN_XOR:  aluSel = SEL_XOR;
          FN_NOR:  aluSel = SEL_NOR;
          FN_SLT:  aluSel = SEL_SLT;
          default: begin aluSel = SEL_ADD; fn_bad = 1'b1; end
        endcase
      end
      default: aluSel = SEL_ADD;
    endcase
  end

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a      (a),
    .b      (b),
    .sel    (aluSel),
    .result (alu_res)
  );

  // EX register next state: capture on enable, otherwise hold
  always_comb begin
    out_d  = out_q;
    zero_d = zero_q;
    ill_d  = ill_q;
    if (en) begin
      out_d  = alu_res;
      zero_d = (alu_res == '0);
      ill_d  = op_bad | fn_bad;
    end
  end

  // EX register; zero flag clears on reset so no branch is taken out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      zero_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      zero_q <= zero_d;
      ill_q  <= ill_d;
    end
  end

  assign out      = out_q;
  assign zeroFlag = zero_q;
  assign illegal  = ill_q;

endmodule

// File: tb/tb_mips_exec_ctrl.sv
// Directed bench for mips_exec_ctrl: vector table plus reset/stall sequences.
module tb_mips_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [5:0]  opCode;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic        regDst, branch, memRead, memtoReg, memWrite, aluSrc, regWrite, jump;
  logic [2:0]  aluOp;
  logic [2:0]  aluSel;
  logic [31:0] out;
  logic        zeroFlag;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_exec_ctrl #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .opCode   (opCode),
    .funct    (funct),
    .a        (a),
    .b        (b),
    .regDst   (regDst),
    .branch   (branch),
    .memRead  (memRead),
    .memtoReg (memtoReg),
    .memWrite (memWrite),
    .aluSrc   (aluSrc),
    .regWrite (regWrite),
    .jump     (jump),
    .aluOp    (aluOp),
    .aluSel   (aluSel),
    .out      (out),
    .zeroFlag (zeroFlag),
    .illegal  (illegal)
  );

  typedef struct {
    string       name;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  ctrl;
    logic [2:0]  aop;
    logic [2:0]  sel;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] ctrl_now();
    return {regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, jump};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] va, input logic [31:0] vb);
    opCode = op;
    funct  = fn;
    a      = va;
    b      = vb;
  endtask

  initial begin
    // name, op, funct, a, b, ctrl, aluOp, aluSel, out, zero, illegal
    vecs.push_back('{"lw",      6'b100011, 6'b000000, 32'd4,        32'd100,      8'h78, 3'b000, 3'b010, 32'd104,      1'b0, 1'b0});
    vecs.push_back('{"beq",     6'b000100, 6'b000000, 32'h1234,     32'h1234,     8'h02, 3'b001, 3'b110, 32'd0,        1'b1, 1'b0});
    vecs.push_back('{"r_sub",   6'b000000, 6'b100010, 32'd5,        32'd3,        8'h90, 3'b010, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{"r_slt",   6'b000000, 6'b101010, 32'd1,        32'hFFFFFFFF, 8'h90, 3'b010, 3'b111, 32'd1,        1'b0, 1'b0});
    vecs.push_back('{"r_nor",   6'b000000, 6'b100111, 32'd0,        32'd0,        8'h90, 3'b010, 3'b100, 32'hFFFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{"r_add",   6'b000000, 6'b100000, 32'd3,        32'd4,        8'h90, 3'b010, 3'b010, 32'd7,        1'b0, 1'b0});
    vecs.push_back('{"r_and",   6'b000000, 6'b100100, 32'hC,        32'hA,        8'h90, 3'b010, 3'b000, 32'h8,        1'b0, 1'b0});
    vecs.push_back('{"r_or",    6'b000000, 6'b100101, 32'hC,        32'hA,        8'h90, 3'b010, 3'b001, 32'hE,        1'b0, 1'b0});
    vecs.push_back('{"r_xor",   6'b000000, 6'b100110, 32'hC,        32'hA,        8'h90, 3'b010, 3'b011, 32'h6,        1'b0, 1'b0});
    vecs.push_back('{"r_badfn", 6'b000000, 6'b000001, 32'd7,        32'd8,        8'h90, 3'b010, 3'b010, 32'd15,       1'b0, 1'b1});
    vecs.push_back('{"sw_wrap", 6'b101011, 6'b000000, 32'hFFFFFFFF, 32'd1,        8'h44, 3'b000, 3'b010, 32'd0,        1'b1, 1'b0});
    vecs.push_back('{"addi",    6'b001000, 6'b000000, 32'd10,       32'd20,       8'h50, 3'b000, 3'b010, 32'd30,       1'b0, 1'b0});
    vecs.push_back('{"andi",    6'b001100, 6'b000000, 32'hF0F0,     32'hFF00,     8'h50, 3'b011, 3'b000, 32'hF000,     1'b0, 1'b0});
    vecs.push_back('{"ori",     6'b001101, 6'b000000, 32'h0F,       32'hF0,       8'h50, 3'b100, 3'b001, 32'hFF,       1'b0, 1'b0});
    vecs.push_back('{"slti_t",  6'b001010, 6'b000000, 32'd5,        32'd3,        8'h50, 3'b101, 3'b111, 32'd1,        1'b0, 1'b0});
    vecs.push_back('{"slti_f",  6'b001010, 6'b000000, 32'hFFFFFFFF, 32'd0,        8'h50, 3'b101, 3'b111, 32'd0,        1'b1, 1'b0});
    vecs.push_back('{"j",       6'b000010, 6'b000000, 32'd1,        32'd1,        8'h01, 3'b000, 3'b010, 32'd2,        1'b0, 1'b0});
    vecs.push_back('{"bad_op",  6'b111111, 6'b100010, 32'd2,        32'd3,        8'h00, 3'b000, 3'b010, 32'd5,        1'b0, 1'b1});

    rst_n = 1'b0;
    en    = 1'b1;
    drive(6'b100011, 6'b0, 32'd4, 32'd100);
    #12;
    chk("reset_out",  out,      32'd0);
    chk("reset_zero", {31'd0, zeroFlag}, 32'd0);
    chk("reset_ill",  {31'd0, illegal},  32'd0);
    chk("reset_comb_ctrl", {24'd0, ctrl_now()}, 32'h78);

    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b);
      #1;
      chk({vecs[i].name, "_ctrl"},  {24'd0, ctrl_now()}, {24'd0, vecs[i].ctrl});
      chk({vecs[i].name, "_aluop"}, {29'd0, aluOp},      {29'd0, vecs[i].aop});
      chk({vecs[i].name, "_alusel"},{29'd0, aluSel},     {29'd0, vecs[i].sel});
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_out"},   out,                 vecs[i].res);
      chk({vecs[i].name, "_zero"},  {31'd0, zeroFlag},   {31'd0, vecs[i].zero});
      chk({vecs[i].name, "_ill"},   {31'd0, illegal},    {31'd0, vecs[i].ill});
    end

    // Stall after the illegal opcode: out=5, zero=0, illegal=1 must hold
    @(negedge clk);
    en = 1'b0;
    drive(6'b101011, 6'b0, 32'hFFFFFFFF, 32'd1);
    @(posedge clk);
    #1;
    chk("stall_out",  out,               32'd5);
    chk("stall_zero", {31'd0, zeroFlag}, 32'd0);
    chk("stall_ill",  {31'd0, illegal},  32'd1);
    @(posedge clk);
    #1;
    chk("stall2_out", out, 32'd5);

    // Release stall: wrap to zero
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    chk("unstall_out",  out,               32'd0);
    chk("unstall_zero", {31'd0, zeroFlag}, 32'd1);
    chk("unstall_ill",  {31'd0, illegal},  32'd0);

    // Load 104, then reset asynchronously between edges
    @(negedge clk);
    drive(6'b100011, 6'b0, 32'd4, 32'd100);
    @(posedge clk);
    #1;
    chk("pre_rst_out", out, 32'd104);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out",  out,               32'd0);
    chk("async_rst_zero", {31'd0, zeroFlag}, 32'd0);
    chk("async_rst_ctrl", {24'd0, ctrl_now()}, 32'h78);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rel_before_edge", out, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_after_edge", out, 32'd104);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
